freelist_alloc_ctrl: RTL and testbench

FREELIST_ALLOC_CTRL -- requirements
Module: freelist_alloc_ctrl

---
 rtl/freelist_alloc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_freelist_alloc_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freelist_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// freelist_alloc_ctrl
//
// Rename-stage allocator in front of a two-port physical-register freelist.
// It grants up to two destination pregs per cycle from the current freelist
// occupancy. It registers commit-time frees and retired allocations for one
// stage before writing them back to the freelist. On an exception it steps
// through a short drain/recover sequence that restores the freelist
// speculative read pointer.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   excep_i                       exception flush request
//   alloc_req{0,1}_i              rename slot needs a destination preg
//   alloc_gnt{0,1}_o              slot granted this cycle (combinational)
//   alloc_preg{0,1}_o             granted preg tag (0 when not granted)
//   commit_free{0,1}_en_i/_preg_i commit releases an old preg
//   commit_alloc{0,1}_en_i        commit retires an allocation
//   fl_wr_{first,second}_en_o     freelist write enables
//   fl_wdata_{first,second}_o     freelist write data
//   fl_rd_{first,second}_en_o     freelist speculative read enables
//   fl_rd_excep_{first,second}_en_o freelist committed read enables
//   fl_excep_rst_o                restore freelist speculative read pointer
//   fl_rdata_{first,second}_i     freelist read data
//   fl_num_i                      freelist occupancy
//   busy_o                        recovery in progress
//   stall_cnt_o                   saturating allocation stall counter
// -----------------------------------------------------------------------------
module freelist_alloc_ctrl #(
   parameter int PREG_WIDTH   = 5,
   parameter int FL_SIZE      = 31,
   parameter int FL_CNT_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    excep_i,
   input  logic                    alloc_req0_i,
   input  logic                    alloc_req1_i,
   output logic                    alloc_gnt0_o,
   output logic                    alloc_gnt1_o,
   output logic [PREG_WIDTH-1:0]   alloc_preg0_o,
   output logic [PREG_WIDTH-1:0]   alloc_preg1_o,
   input  logic                    commit_free0_en_i,
   input  logic                    commit_free1_en_i,
   input  logic [PREG_WIDTH-1:0]   commit_free0_preg_i,
   input  logic [PREG_WIDTH-1:0]   commit_free1_preg_i,
   input  logic                    commit_alloc0_en_i,
   input  logic                    commit_alloc1_en_i,
   output logic                    fl_wr_first_en_o,
   output logic                    fl_wr_second_en_o,
   output logic [PREG_WIDTH-1:0]   fl_wdata_first_o,
   output logic [PREG_WIDTH-1:0]   fl_wdata_second_o,
   output logic                    fl_rd_first_en_o,
   output logic                    fl_rd_second_en_o,
   output logic                    fl_rd_excep_first_en_o,
   output logic                    fl_rd_excep_second_en_o,
   output logic                    fl_excep_rst_o,
   input  logic [PREG_WIDTH-1:0]   fl_rdata_first_i,
   input  logic [PREG_WIDTH-1:0]   fl_rdata_second_i,
   input  logic [FL_CNT_WIDTH:0]   fl_num_i,
   output logic                    busy_o,
   output logic [15:0]             stall_cnt_o
);

   localparam int CNT_W = FL_CNT_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_NORMAL,
      ST_DRAIN,
      ST_RECOVER
   } state_e;

   typedef struct packed {
      logic                  free0_en;
      logic [PREG_WIDTH-1:0] free0_preg;
      logic                  free1_en;
      logic [PREG_WIDTH-1:0] free1_preg;
      logic                  alloc0_en;
      logic                  alloc1_en;
   } commit_s;

   state_e      state_q, state_d;
   commit_s     commit_q, commit_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic             alloc_ok;
   logic             gnt0, gnt1;
   logic             stall_evt;
   logic [CNT_W-1:0] fl_num_eff;

   // Occupancy above the physical freelist size cannot happen legally; clamp
   // it so a corrupted count never over-grants.
   assign fl_num_eff = (fl_num_i > CNT_W'(FL_SIZE)) ? CNT_W'(FL_SIZE) : fl_num_i;

   // NOTE: state is registered with non-blocking assignments only; all
   // next-state logic lives in the always_comb below.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_NORMAL;
         commit_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         commit_q    <= commit_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // infer a latch.
   always_comb begin
      state_d     = state_q;
      commit_d    = '0;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      stall_evt   = 1'b0;
      stall_cnt_d = stall_cnt_q;

      unique case (state_q)
         ST_NORMAL:  if (excep_i) state_d = ST_DRAIN;
         ST_DRAIN:   state_d = ST_RECOVER;
         ST_RECOVER: state_d = ST_NORMAL;
         default:    state_d = ST_NORMAL;
      endcase

      // Commits are captured even in the excep_i cycle. The DRAIN cycle then
      // applies them, and the RECOVER pointer restore sees a settled freelist.
      if (state_q == ST_NORMAL) begin
         commit_d.free0_en   = commit_free0_en_i;
         commit_d.free0_preg = commit_free0_preg_i;
         commit_d.free1_en   = commit_free1_en_i;
         commit_d.free1_preg = commit_free1_preg_i;
         commit_d.alloc0_en  = commit_alloc0_en_i;
         commit_d.alloc1_en  = commit_alloc1_en_i;
      end

      if (alloc_ok) begin
         if (alloc_req0_i && alloc_req1_i) begin
            gnt0 = (fl_num_eff >= CNT_W'(1));
            gnt1 = (fl_num_eff >= CNT_W'(2));
         end else if (alloc_req0_i) begin
            gnt0 = (fl_num_eff >= CNT_W'(1));
         end else if (alloc_req1_i) begin
            gnt1 = (fl_num_eff >= CNT_W'(1));
         end
         stall_evt = (alloc_req0_i && !gnt0) || (alloc_req1_i && !gnt1);
      end

      if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   assign alloc_ok = (state_q == ST_NORMAL) && !excep_i && !rst;

   assign alloc_gnt0_o      = gnt0;
   assign alloc_gnt1_o      = gnt1;
   assign alloc_preg0_o     = gnt0 ? fl_rdata_first_i  : '0;
   assign alloc_preg1_o     = gnt1 ? fl_rdata_second_i : '0;
   assign fl_rd_first_en_o  = gnt0;
   assign fl_rd_second_en_o = gnt1;

   // Freelist enables are masked while rst is held, so a stage captured just
   // before reset never reaches the freelist.
   assign fl_wr_first_en_o        = commit_q.free0_en  && !rst;
   assign fl_wr_second_en_o       = commit_q.free1_en  && !rst;
   assign fl_wdata_first_o        = fl_wr_first_en_o  ? commit_q.free0_preg : '0;
   assign fl_wdata_second_o       = fl_wr_second_en_o ? commit_q.free1_preg : '0;
   assign fl_rd_excep_first_en_o  = commit_q.alloc0_en && !rst;
   assign fl_rd_excep_second_en_o = commit_q.alloc1_en && !rst;

   assign fl_excep_rst_o = (state_q == ST_RECOVER) && !rst;
   assign busy_o         = (state_q != ST_NORMAL);
   assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_freelist_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freelist_alloc_ctrl
//
// Directed bench for freelist_alloc_ctrl. Grant-side outputs are checked
// against constants within the cycle. Commit-stage outputs go through a
// scoreboard: each clock pushes the stage contents expected one cycle later,
// and they are popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_freelist_alloc_ctrl;

   localparam int PW  = 5;
   localparam int CW  = 5;
   localparam int SBW = 2 * PW + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          excep_i;
   logic          alloc_req0_i, alloc_req1_i;
   logic          alloc_gnt0_o, alloc_gnt1_o;
   logic [PW-1:0] alloc_preg0_o, alloc_preg1_o;
   logic          commit_free0_en_i, commit_free1_en_i;
   logic [PW-1:0] commit_free0_preg_i, commit_free1_preg_i;
   logic          commit_alloc0_en_i, commit_alloc1_en_i;
   logic          fl_wr_first_en_o, fl_wr_second_en_o;
   logic [PW-1:0] fl_wdata_first_o, fl_wdata_second_o;
   logic          fl_rd_first_en_o, fl_rd_second_en_o;
   logic          fl_rd_excep_first_en_o, fl_rd_excep_second_en_o;
   logic          fl_excep_rst_o;
   logic [PW-1:0] fl_rdata_first_i, fl_rdata_second_i;
   logic [CW:0]   fl_num_i;
   logic          busy_o;
   logic [15:0]   stall_cnt_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [SBW-1:0] sb_q[$];

   freelist_alloc_ctrl #(
      .PREG_WIDTH  (PW),
      .FL_SIZE     (31),
      .FL_CNT_WIDTH(CW)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .excep_i                (excep_i),
      .alloc_req0_i           (alloc_req0_i),
      .alloc_req1_i           (alloc_req1_i),
      .alloc_gnt0_o           (alloc_gnt0_o),
      .alloc_gnt1_o           (alloc_gnt1_o),
      .alloc_preg0_o          (alloc_preg0_o),
      .alloc_preg1_o          (alloc_preg1_o),
      .commit_free0_en_i      (commit_free0_en_i),
      .commit_free1_en_i      (commit_free1_en_i),
      .commit_free0_preg_i    (commit_free0_preg_i),
      .commit_free1_preg_i    (commit_free1_preg_i),
      .commit_alloc0_en_i     (commit_alloc0_en_i),
      .commit_alloc1_en_i     (commit_alloc1_en_i),
      .fl_wr_first_en_o       (fl_wr_first_en_o),
      .fl_wr_second_en_o      (fl_wr_second_en_o),
      .fl_wdata_first_o       (fl_wdata_first_o),
      .fl_wdata_second_o      (fl_wdata_second_o),
      .fl_rd_first_en_o       (fl_rd_first_en_o),
      .fl_rd_second_en_o      (fl_rd_second_en_o),
      .fl_rd_excep_first_en_o (fl_rd_excep_first_en_o),
      .fl_rd_excep_second_en_o(fl_rd_excep_second_en_o),
      .fl_excep_rst_o         (fl_excep_rst_o),
      .fl_rdata_first_i       (fl_rdata_first_i),
      .fl_rdata_second_i      (fl_rdata_second_i),
      .fl_num_i               (fl_num_i),
      .busy_o                 (busy_o),
      .stall_cnt_o            (stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock. cap says whether the DUT is in NORMAL (and out of reset),
   // i.e. whether the present commit inputs must appear on the freelist
   // write/read-excep ports one cycle later.
   task automatic tick(input bit cap);
      logic [SBW-1:0] e, o;
      e = '0;
      if (cap) begin
         e = {commit_free0_en_i, commit_free0_en_i ? commit_free0_preg_i : 5'd0,
              commit_free1_en_i, commit_free1_en_i ? commit_free1_preg_i : 5'd0,
              commit_alloc0_en_i, commit_alloc1_en_i};
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      o = {fl_wr_first_en_o, fl_wdata_first_o, fl_wr_second_en_o, fl_wdata_second_o,
           fl_rd_excep_first_en_o, fl_rd_excep_second_en_o};
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         check("commit_stage", 32'(o), 32'(sb_q.pop_front()));
      end
   endtask

   task automatic set_commit(input logic f0, input logic [PW-1:0] p0, input logic f1,
                             input logic [PW-1:0] p1, input logic a0, input logic a1);
      commit_free0_en_i   = f0;
      commit_free0_preg_i = p0;
      commit_free1_en_i   = f1;
      commit_free1_preg_i = p1;
      commit_alloc0_en_i  = a0;
      commit_alloc1_en_i  = a1;
   endtask

   initial begin
      rst = 1'b1;  excep_i = 1'b0;
      alloc_req0_i = 1'b1;  alloc_req1_i = 1'b1;
      fl_num_i = 6'd31;  fl_rdata_first_i = 5'd1;  fl_rdata_second_i = 5'd2;
      set_commit(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1);

      // Reset: requests and commits are active, yet nothing may be granted
      // or written while rst is held.
      tick(1'b0);
      tick(1'b0);
      check("rst_gnt0", 32'(alloc_gnt0_o), 32'd0);
      check("rst_gnt1", 32'(alloc_gnt1_o), 32'd0);
      check("rst_rd_first_en", 32'(fl_rd_first_en_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_excep_rst", 32'(fl_excep_rst_o), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);

      // Dual grant from a full freelist.
      rst = 1'b0;
      set_commit(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      check("dual_gnt0", 32'(alloc_gnt0_o), 32'd1);
      check("dual_gnt1", 32'(alloc_gnt1_o), 32'd1);
      check("dual_preg0", 32'(alloc_preg0_o), 32'd1);
      check("dual_preg1", 32'(alloc_preg1_o), 32'd2);
      check("dual_rd_first_en", 32'(fl_rd_first_en_o), 32'd1);
      check("dual_rd_second_en", 32'(fl_rd_second_en_o), 32'd1);
      tick(1'b1);
      check("dual_no_stall", 32'(stall_cnt_o), 32'd0);

      // One entry left, two requests: only slot 0 wins and a stall is counted.
      fl_num_i = 6'd1;
      #1;
      check("one_gnt0", 32'(alloc_gnt0_o), 32'd1);
      check("one_gnt1", 32'(alloc_gnt1_o), 32'd0);
      check("one_preg1_zero", 32'(alloc_preg1_o), 32'd0);
      tick(1'b1);
      check("one_stall_cnt", 32'(stall_cnt_o), 32'd1);

      // Empty freelist, slot 1 only.
      alloc_req0_i = 1'b0;  fl_num_i = 6'd0;
      #1;
      check("empty_gnt0", 32'(alloc_gnt0_o), 32'd0);
      check("empty_gnt1", 32'(alloc_gnt1_o), 32'd0);
      tick(1'b1);
      check("empty_stall_cnt", 32'(stall_cnt_o), 32'd2);

      // Lone slot-1 grant takes the second read port's data.
      fl_num_i = 6'd5;  fl_rdata_second_i = 5'd7;
      #1;
      check("s1_gnt1", 32'(alloc_gnt1_o), 32'd1);
      check("s1_preg1", 32'(alloc_preg1_o), 32'd7);
      check("s1_preg0_zero", 32'(alloc_preg0_o), 32'd0);
      check("s1_rd_first_en", 32'(fl_rd_first_en_o), 32'd0);
      check("s1_rd_second_en", 32'(fl_rd_second_en_o), 32'd1);
      tick(1'b1);
      check("s1_no_stall", 32'(stall_cnt_o), 32'd2);

      // Commit-stage write mapping: free1 only, both, free0 + alloc1.
      alloc_req1_i = 1'b0;
      set_commit(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
      tick(1'b1);
      check("free1_wr_second_en", 32'(fl_wr_second_en_o), 32'd1);
      check("free1_wdata_second", 32'(fl_wdata_second_o), 32'd9);
      check("free1_wr_first_en", 32'(fl_wr_first_en_o), 32'd0);
      set_commit(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
      tick(1'b1);
      set_commit(1'b1, 5'd6, 1'b0, 5'd12, 1'b0, 1'b1);
      tick(1'b1);
      set_commit(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick(1'b1);

      // Exception at T with live requests and a retired allocation.
      alloc_req0_i = 1'b1;  alloc_req1_i = 1'b1;  fl_num_i = 6'd31;
      excep_i = 1'b1;
      set_commit(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      #1;
      check("excep_T_gnt0", 32'(alloc_gnt0_o), 32'd0);
      check("excep_T_gnt1", 32'(alloc_gnt1_o), 32'd0);
      tick(1'b1);
      // T+1: DRAIN; the captured alloc0 retire is applied. excep_i stays high
      // and new commits are driven; both must be ignored.
      set_commit(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 1'b1);
      #1;
      check("drain_busy", 32'(busy_o), 32'd1);
      check("drain_rd_excep_first", 32'(fl_rd_excep_first_en_o), 32'd1);
      check("drain_excep_rst", 32'(fl_excep_rst_o), 32'd0);
      check("drain_gnt0", 32'(alloc_gnt0_o), 32'd0);
      tick(1'b0);
      // T+2: RECOVER.
      check("recover_excep_rst", 32'(fl_excep_rst_o), 32'd1);
      check("recover_busy", 32'(busy_o), 32'd1);
      check("recover_gnt1", 32'(alloc_gnt1_o), 32'd0);
      excep_i = 1'b0;
      set_commit(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick(1'b0);
      // T+3: back to NORMAL.
      check("resume_busy", 32'(busy_o), 32'd0);
      check("resume_excep_rst", 32'(fl_excep_rst_o), 32'd0);
      check("resume_gnt0", 32'(alloc_gnt0_o), 32'd1);
      check("resume_gnt1", 32'(alloc_gnt1_o), 32'd1);
      check("resume_stall_cnt", 32'(stall_cnt_o), 32'd2);
      tick(1'b1);

      // Drive the stall counter to saturation.
      alloc_req1_i = 1'b0;  fl_num_i = 6'd0;
      for (int i = 0; i < 65532; i++) tick(1'b1);
      check("stall_fffe", 32'(stall_cnt_o), 32'hFFFE);
      tick(1'b1);
      check("stall_ffff", 32'(stall_cnt_o), 32'hFFFF);
      tick(1'b1);
      check("stall_saturated", 32'(stall_cnt_o), 32'hFFFF);

      // Reset while in RECOVER aborts the sequence.
      alloc_req0_i = 1'b0;
      excep_i = 1'b1;
      tick(1'b1);
      excep_i = 1'b0;
      tick(1'b0);
      check("pre_abort_excep_rst", 32'(fl_excep_rst_o), 32'd1);
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      check("abort_excep_rst", 32'(fl_excep_rst_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_stall_cnt", 32'(stall_cnt_o), 32'd0);
      alloc_req0_i = 1'b1;  fl_num_i = 6'd3;  fl_rdata_first_i = 5'd13;
      #1;
      check("abort_gnt0", 32'(alloc_gnt0_o), 32'd1);
      check("abort_preg0", 32'(alloc_preg0_o), 32'd13);
      tick(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
